// File: rtl/dff_pkg.sv
// Shared definitions for the single-bit D-flip-flop serial link.
// Both the transmitter and the matching receiver import this package.
package dff_pkg;

  // Frame sequencer states; all four 2-bit codes are used.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_SHIFT = 2'd2,
    ST_STOP  = 2'd3
  } dff_state_t;

  // Bit-counter width for a frame of 'width' data bits (counter runs 0..width-1).
  // Floor of 1 keeps the counter a legal vector for degenerate widths.
  function automatic int dff_cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/dff_serial_tx.sv
// Parallel-to-serial transmitter driving a single registered serial line.
// Frame = one start bit (~IDLE_LEVEL), WIDTH data bits, one stop bit (IDLE_LEVEL).
// A word is taken on a valid/ready handshake; the next word can be accepted
// during the stop bit, so back-to-back frames have no idle gap.
module dff_serial_tx
  import dff_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter int   MSB_FIRST  = 1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             ser_out,
  output logic             ser_outb,
  output logic             ser_frame,
  output logic             busy,
  output logic             done
);

  localparam int CW = dff_cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  dff_state_t       state_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    cnt_reg;
  logic             ser_out_reg;
  logic             ser_frame_reg;
  logic             busy_reg;
  logic             done_reg;

  logic             accept;
  logic [WIDTH-1:0] load_word;
  logic [WIDTH-1:0] shift_next;
  logic             next_bit;

  // The word is reordered once at load time so the shifter always emits its MSB;
  // for LSB-first operation this is a plain bit reversal of tx_data.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_load_order
      if (MSB_FIRST != 0) begin : g_msb
        assign load_word[gi] = tx_data[gi];
      end else begin : g_lsb
        assign load_word[gi] = tx_data[WIDTH-1-gi];
      end
    end
  endgenerate

  assign next_bit   = shift_reg[WIDTH-1];
  assign shift_next = {shift_reg[WIDTH-2:0], 1'b0};

  // Ready is decoded straight from state so a word can be taken during the stop bit.
  assign tx_ready = (state_reg == ST_IDLE) || (state_reg == ST_STOP);
  assign accept   = tx_valid && tx_ready;

  assign ser_out   = ser_out_reg;
  assign ser_outb  = ~ser_out_reg;
  assign ser_frame = ser_frame_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

  // Frame sequencer: state, shifter, bit counter and all registered line outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      shift_reg     <= '0;
      cnt_reg       <= '0;
      ser_out_reg   <= IDLE_LEVEL;
      ser_frame_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            state_reg     <= ST_START;
            shift_reg     <= load_word;
            cnt_reg       <= '0;
            ser_out_reg   <= ~IDLE_LEVEL;
            ser_frame_reg <= 1'b1;
            busy_reg      <= 1'b1;
            done_reg      <= 1'b0;
          end else begin
            ser_out_reg   <= IDLE_LEVEL;
            ser_frame_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
          end
        end

        ST_START: begin
          // First data bit goes on the line at the end of the start bit.
          state_reg     <= ST_SHIFT;
          ser_out_reg   <= next_bit;
          shift_reg     <= shift_next;
          cnt_reg       <= '0;
          ser_frame_reg <= 1'b1;
          busy_reg      <= 1'b1;
          done_reg      <= 1'b0;
        end

        ST_SHIFT: begin
          // cnt_reg is the index of the bit currently on the line.
          if (cnt_reg == LAST_BIT) begin
            state_reg     <= ST_STOP;
            ser_out_reg   <= IDLE_LEVEL;
            ser_frame_reg <= 1'b0;
            done_reg      <= 1'b1;
            cnt_reg       <= '0;
          end else begin
            ser_out_reg   <= next_bit;
            shift_reg     <= shift_next;
            cnt_reg       <= cnt_reg + CW'(1);
          end
          busy_reg <= 1'b1;
        end

        ST_STOP: begin
          if (accept) begin
            state_reg     <= ST_START;
            shift_reg     <= load_word;
            cnt_reg       <= '0;
            ser_out_reg   <= ~IDLE_LEVEL;
            ser_frame_reg <= 1'b1;
            busy_reg      <= 1'b1;
            done_reg      <= 1'b0;
          end else begin
            state_reg     <= ST_IDLE;
            ser_out_reg   <= IDLE_LEVEL;
            ser_frame_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
          end
        end

        default: begin
          state_reg     <= ST_IDLE;
          cnt_reg       <= '0;
          ser_out_reg   <= IDLE_LEVEL;
          ser_frame_reg <= 1'b0;
          busy_reg      <= 1'b0;
          done_reg      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dff_serial_tx.sv
// Bench for dff_serial_tx: two instances (MSB-first/idle-low and LSB-first/idle-high)
// run side by side and are compared every cycle against a frame-position model.
module tb_dff_serial_tx;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [1:0]        tx_valid;
  logic [1:0][W-1:0] tx_data;
  logic [1:0]        tx_ready, ser_out, ser_outb, ser_frame, busy, done;

  dff_serial_tx #(.WIDTH(W), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) dut_msb (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .ser_out(ser_out[0]), .ser_outb(ser_outb[0]),
    .ser_frame(ser_frame[0]), .busy(busy[0]), .done(done[0])
  );

  dff_serial_tx #(.WIDTH(W), .MSB_FIRST(0), .IDLE_LEVEL(1'b1)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .ser_out(ser_out[1]), .ser_outb(ser_outb[1]),
    .ser_frame(ser_frame[1]), .busy(busy[1]), .done(done[1])
  );

  // Per-instance configuration as seen by the model.
  localparam logic [1:0] IDLE_LV = 2'b10;
  localparam logic [1:0] MSB_F   = 2'b01;

  // Model: pos = -1 when idle, otherwise the cycle index within the frame
  // (0 = start bit, 1..W = data bits, W+1 = stop bit).
  int         pos [2];
  logic [W-1:0] word [2];
  logic       acc [2];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_line(input int i);
    if (pos[i] < 0 || pos[i] == W + 1) return IDLE_LV[i];
    if (pos[i] == 0) return ~IDLE_LV[i];
    if (MSB_F[i]) return word[i][W - pos[i]];
    return word[i][pos[i] - 1];
  endfunction

  task automatic check_all();
    logic e, eb, fr, bz, dn, rd;
    for (int i = 0; i < 2; i++) begin
      e  = exp_line(i);
      eb = ~e;
      fr = (pos[i] >= 0) && (pos[i] <= W);
      bz = (pos[i] >= 0);
      dn = (pos[i] == W + 1);
      rd = (pos[i] < 0) || (pos[i] == W + 1);
      chk($sformatf("u%0d.ser_out", i),   ser_out[i],   e);
      chk($sformatf("u%0d.ser_outb", i),  ser_outb[i],  eb);
      chk($sformatf("u%0d.ser_frame", i), ser_frame[i], fr);
      chk($sformatf("u%0d.busy", i),      busy[i],      bz);
      chk($sformatf("u%0d.done", i),      done[i],      dn);
      chk($sformatf("u%0d.tx_ready", i),  tx_ready[i],  rd);
    end
  endtask

  // One clock: check outputs produced by the previous edge, drive inputs for the
  // next edge, and advance the model to what that edge should produce.
  task automatic step(input logic rst, input logic v0, input logic [W-1:0] d0,
                      input logic v1, input logic [W-1:0] d1);
    logic rdy;
    @(negedge clk);
    check_all();
    rst_n      = rst;
    tx_valid   = {v1, v0};
    tx_data[0] = d0;
    tx_data[1] = d1;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        pos[i] = -1;
        acc[i] = 1'b0;
      end
      #1;
      check_all();
    end else begin
      for (int i = 0; i < 2; i++) begin
        rdy    = (pos[i] < 0) || (pos[i] == W + 1);
        acc[i] = tx_valid[i] && rdy;
        if (acc[i]) begin
          pos[i]  = 0;
          word[i] = tx_data[i];
        end else if (rdy) begin
          pos[i] = -1;
        end else begin
          pos[i] = pos[i] + 1;
        end
      end
    end
  endtask

  task automatic idle_steps(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  initial begin
    logic [1:0]        v;
    logic [1:0][W-1:0] d;
    int                rst_cnt;

    rst_n    = 1'b0;
    tx_valid = '0;
    tx_data  = '0;
    for (int i = 0; i < 2; i++) begin
      pos[i]  = -1;
      word[i] = '0;
      acc[i]  = 1'b0;
    end

    // Reset state.
    step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);

    // Single frames: A5, 01, 00.
    step(1'b1, 1'b1, 8'hA5, 1'b1, 8'hA5);
    idle_steps(12);
    step(1'b1, 1'b1, 8'h01, 1'b1, 8'h01);
    idle_steps(12);
    step(1'b1, 1'b1, 8'h00, 1'b1, 8'h00);
    idle_steps(12);

    // Back-to-back: 3C accepted, C3 held pending until the stop bit.
    step(1'b1, 1'b1, 8'h3C, 1'b1, 8'h3C);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 8'hC3, 1'b1, 8'hC3);
    idle_steps(12);

    // tx_data changed to FF right after accepting 00.
    step(1'b1, 1'b1, 8'h00, 1'b1, 8'h00);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 8'hFF, 1'b1, 8'hFF);
    idle_steps(12);

    // Reset during data bit 4, held two cycles, then a clean frame.
    step(1'b1, 1'b1, 8'h5A, 1'b1, 8'h5A);
    idle_steps(5);
    step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    idle_steps(1);
    step(1'b1, 1'b1, 8'hC6, 1'b1, 8'hC6);
    idle_steps(12);

    // Randomized traffic with upstream holding valid until accepted.
    v       = '0;
    d       = '0;
    rst_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!(v[i] && !acc[i])) begin
          v[i] = ($urandom_range(0, 2) != 0);
          d[i] = W'($urandom);
        end
      end
      if (rst_cnt > 0) rst_cnt--;
      else if ($urandom_range(0, 299) == 0) rst_cnt = 2;
      step(rst_cnt == 0, v[0], d[0], v[1], d[1]);
    end

    @(negedge clk);
    check_all();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
